param_reg_bank: RTL and testbench

PARAM_REG_BANK -- requirements
Module: param_reg_bank

---
 rtl/param_reg_bank.sv | 91 +++++++++
 tb/tb_param_reg_bank.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/param_reg_bank.sv
// Parameter register bank: fill DW-bit words, then stream them out in write order, widened to OW bits.
// Optional macro PARAM_REG_BANK_SIGNEXT_EN selects sign extension instead of zero extension on read-out.
module param_reg_bank #(
   parameter int DW    = 8,
   parameter int OW    = 21,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       wr_valid,
   output logic                       wr_ready,
   input  logic [DW-1:0]              wr_data,
   input  logic                       rd_start,
   output logic                       rd_valid,
   input  logic                       rd_ready,
   output logic [OW-1:0]              rd_data,
   output logic                       rd_last,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   typedef enum logic {FILL = 1'b0, STREAM = 1'b1} state_t;

   state_t          state;
   logic [DW-1:0]   mem [DEPTH];
   logic [PW-1:0]   rptr;
   logic [CW-1:0]   rptr_ext;
   logic            wr_acc;

   function automatic logic [OW-1:0] ext(input logic [DW-1:0] e);
`ifdef PARAM_REG_BANK_SIGNEXT_EN
      ext = OW'($signed(e));
`else
      ext = OW'(e);
`endif
   endfunction

   // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
   assign full     = (count == CW'(DEPTH));
   assign wr_ready = (state == FILL) && !full;
   assign wr_acc   = wr_valid && wr_ready;
   assign rd_valid = (state == STREAM);
   assign rptr_ext = CW'(rptr);
   assign rd_last  = rd_valid && (rptr_ext == count - CW'(1));
   assign rd_data  = rd_valid ? ext(mem[rptr]) : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= FILL;
         count <= '0;
         rptr  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (clr) begin
         // Entries are kept; only the bookkeeping is cleared.
         state <= FILL;
         count <= '0;
         rptr  <= '0;
      end else begin
         case (state)
            FILL: begin
               if (wr_acc) begin
                  mem[count[PW-1:0]] <= wr_data;
                  count              <= count + CW'(1);
               end
               // A write on the same edge counts toward a non-empty bank.
               if (rd_start && ((count != '0) || wr_acc)) begin
                  state <= STREAM;
                  rptr  <= '0;
               end
            end
            STREAM: begin
               if (rd_ready) begin
                  if (rd_last) begin
                     state <= FILL;
                     count <= '0;
                     rptr  <= '0;
                  end else begin
                     rptr <= rptr + PW'(1);
                  end
               end
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_param_reg_bank.sv
// Directed self-checking bench for param_reg_bank (DW=8, OW=21, DEPTH=8).
module tb_param_reg_bank;

   logic        clk;
   logic        rst;
   logic        clr;
   logic        wr_valid;
   logic        wr_ready;
   logic [7:0]  wr_data;
   logic        rd_start;
   logic        rd_valid;
   logic        rd_ready;
   logic [20:0] rd_data;
   logic        rd_last;
   logic [3:0]  count;
   logic        full;

   int n_checks = 0;
   int n_err    = 0;
   int xfers;

`ifdef PARAM_REG_BANK_SIGNEXT_EN
   localparam logic [31:0] EXP_83 = 32'h1FFF83;
`else
   localparam logic [31:0] EXP_83 = 32'h000083;
`endif

   param_reg_bank #(.DW(8), .OW(21), .DEPTH(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_data  (wr_data),
      .rd_start (rd_start),
      .rd_valid (rd_valid),
      .rd_ready (rd_ready),
      .rd_data  (rd_data),
      .rd_last  (rd_last),
      .count    (count),
      .full     (full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic write_word(input logic [7:0] d);
      wr_valid = 1'b1;
      wr_data  = d;
      step();
      wr_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; wr_valid = 1'b0; wr_data = '0;
      rd_start = 1'b0; rd_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // reset state
      check("rst_wr_ready", 32'(wr_ready), 32'd1);
      check("rst_rd_valid", 32'(rd_valid), 32'd0);
      check("rst_rd_last",  32'(rd_last),  32'd0);
      check("rst_rd_data",  32'(rd_data),  32'd0);
      check("rst_full",     32'(full),     32'd0);
      check("rst_count",    32'(count),    32'd0);

      // basic fill and stream, extension of 0x83
      write_word(8'h05);
      write_word(8'h83);
      write_word(8'h7F);
      check("t1_count", 32'(count), 32'd3);
      rd_start = 1'b1; step(); rd_start = 1'b0;
      rd_ready = 1'b1;
      check("t1_valid0", 32'(rd_valid), 32'd1);
      check("t1_data0",  32'(rd_data),  32'h05);
      check("t1_last0",  32'(rd_last),  32'd0);
      step();
      check("t1_data1",  32'(rd_data),  EXP_83);
      check("t1_last1",  32'(rd_last),  32'd0);
      step();
      check("t1_data2",  32'(rd_data),  32'h7F);
      check("t1_last2",  32'(rd_last),  32'd1);
      step();
      rd_ready = 1'b0;
      check("t1_valid_end", 32'(rd_valid), 32'd0);
      check("t1_count_end", 32'(count),    32'd0);

      // fill to full with wr_valid held, then a 9th offered word
      wr_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         wr_data = 8'(8'h20 + i);
         step();
      end
      check("t2_full",     32'(full),     32'd1);
      check("t2_wr_ready", 32'(wr_ready), 32'd0);
      check("t2_count8",   32'(count),    32'd8);
      wr_data = 8'h99;
      step();
      wr_valid = 1'b0;
      check("t2_count9",   32'(count),    32'd8);
      rd_start = 1'b1; step(); rd_start = 1'b0;
      rd_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("t2_data", 32'(rd_data), 32'h20 + 32'(i));
         check("t2_last", 32'(rd_last), (i == 7) ? 32'd1 : 32'd0);
         step();
      end
      rd_ready = 1'b0;
      check("t2_valid_end", 32'(rd_valid), 32'd0);
      check("t2_count_end", 32'(count),    32'd0);

      // back-pressure on the second word
      write_word(8'h51);
      write_word(8'h52);
      write_word(8'h53);
      rd_start = 1'b1; step(); rd_start = 1'b0;
      xfers = 0;
      rd_ready = 1'b1;
      check("t3_data0", 32'(rd_data), 32'h51);
      if (rd_valid && rd_ready) xfers++;
      step();
      rd_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("t3_hold_data", 32'(rd_data), 32'h52);
         check("t3_hold_last", 32'(rd_last), 32'd0);
         step();
      end
      rd_ready = 1'b1;
      check("t3_data1", 32'(rd_data), 32'h52);
      if (rd_valid && rd_ready) xfers++;
      step();
      check("t3_data2", 32'(rd_data), 32'h53);
      check("t3_last2", 32'(rd_last), 32'd1);
      if (rd_valid && rd_ready) xfers++;
      step();
      if (rd_valid && rd_ready) xfers++;
      rd_ready = 1'b0;
      check("t3_xfers", 32'(xfers), 32'd3);
      check("t3_valid_end", 32'(rd_valid), 32'd0);

      // rd_start on empty bank, then rd_start with the first write
      rd_start = 1'b1; step(); rd_start = 1'b0;
      check("t4_empty_valid",    32'(rd_valid), 32'd0);
      check("t4_empty_wr_ready", 32'(wr_ready), 32'd1);
      wr_valid = 1'b1; wr_data = 8'h11; rd_start = 1'b1;
      step();
      wr_valid = 1'b0; rd_start = 1'b0;
      check("t4_valid", 32'(rd_valid), 32'd1);
      check("t4_data",  32'(rd_data),  32'h11);
      check("t4_last",  32'(rd_last),  32'd1);
      check("t4_count", 32'(count),    32'd1);
      rd_ready = 1'b1; step(); rd_ready = 1'b0;
      check("t4_valid_end", 32'(rd_valid), 32'd0);
      check("t4_count_end", 32'(count),    32'd0);

      // clr at rptr=1 with a same-edge read handshake
      write_word(8'h31);
      write_word(8'h32);
      write_word(8'h33);
      rd_start = 1'b1; step(); rd_start = 1'b0;
      rd_ready = 1'b1; step();
      check("t5_data1", 32'(rd_data), 32'h32);
      clr = 1'b1;
      check("t5_valid_pre", 32'(rd_valid), 32'd1);
      step();
      clr = 1'b0; rd_ready = 1'b0;
      check("t5_valid",    32'(rd_valid), 32'd0);
      check("t5_count",    32'(count),    32'd0);
      check("t5_wr_ready", 32'(wr_ready), 32'd1);

      // asynchronous rst mid-stream
      write_word(8'h41);
      write_word(8'h42);
      rd_start = 1'b1; step(); rd_start = 1'b0;
      check("t6_valid_pre", 32'(rd_valid), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("t6_valid",    32'(rd_valid), 32'd0);
      check("t6_count",    32'(count),    32'd0);
      check("t6_wr_ready", 32'(wr_ready), 32'd1);
      check("t6_rd_data",  32'(rd_data),  32'd0);
      #1 rst = 1'b0;
      step();
      check("t6_after_valid", 32'(rd_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
